datapath_p2: RTL and testbench



---
 rtl/datapath_p2.sv | 172 +++++++++++++++++
 tb/tb_datapath_p2.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_p2.sv
// datapath_p2: single-bus 32-bit SRC-style datapath.
// The control unit drives every transfer strobe. This block only moves data
// between registers over one shared bus. The bus is exported on outp.
module datapath_p2 (
    output logic [31:0] outp,
    input  logic        PCout,
    input  logic        Zhiout,
    input  logic        Zlowout,
    input  logic        MDRout,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        InPortout,
    input  logic        MARin,
    input  logic        Zin,
    input  logic        PCin,
    input  logic        MDRin,
    input  logic        IRin,
    input  logic        Yin,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        OutPortin,
    input  logic        IncPC,
    input  logic        Read,
    input  logic        Write,
    input  logic        ReadEn,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        Rin,
    input  logic        Rout,
    input  logic        BAout,
    input  logic        Cout,
    input  logic        CONIn,
    input  logic        Strobe,
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] Mdatain,
    input  logic [31:0] InPort_data,
    input  logic        SUB,
    input  logic        AND,
    input  logic        ADD
);

    logic [31:0] r_regs [0:15];
    logic [31:0] r_pc, r_ir, r_mar, r_mdr, r_y, r_hi, r_lo;
    logic [31:0] r_inport, r_outport;
    logic [63:0] r_z;
    logic        r_con;
    logic [31:0] r_ram [0:511];

    logic [15:0] w_sel;
    logic [31:0] w_reg_val;
    logic [31:0] w_bus;
    logic [31:0] w_cval;
    logic [31:0] w_ram_rd;
    logic [31:0] w_mdr_in;
    logic [31:0] w_alu;
    logic        w_con_next;
    logic        w_unused;

    // OutPort and CON are observed from outside the block. MAR above bit 8 and
    // the opcode field have no consumer inside the datapath.
    assign w_unused = ^{r_mar[31:9], r_ir[31:27], r_outport, r_con};

    assign w_cval   = {{13{r_ir[18]}}, r_ir[18:0]};
    assign w_ram_rd = r_ram[r_mar[8:0]];
    assign outp     = w_bus;

    // One-hot register select: OR of the decoded Ra/Rb/Rc fields that are enabled.
    always_comb begin
        w_sel = '0;
        if (Gra) w_sel[r_ir[26:23]] = 1'b1;
        if (Grb) w_sel[r_ir[22:19]] = 1'b1;
        if (Grc) w_sel[r_ir[18:15]] = 1'b1;
    end

    // The lowest-numbered selected register is the one driven onto the bus.
    always_comb begin
        w_reg_val = '0;
        for (int i = 15; i >= 0; i--) begin
            if (w_sel[i]) w_reg_val = r_regs[i];
        end
    end

    // Bus source mux in fixed priority order. BAout reads R0 as zero.
    always_comb begin
        w_bus = '0;
        if (MDRout)         w_bus = r_mdr;
        else if (PCout)     w_bus = r_pc;
        else if (Zlowout)   w_bus = r_z[31:0];
        else if (Zhiout)    w_bus = r_z[63:32];
        else if (HIout)     w_bus = r_hi;
        else if (LOout)     w_bus = r_lo;
        else if (InPortout) w_bus = r_inport;
        else if (Cout)      w_bus = w_cval;
        else if (Rout)      w_bus = w_reg_val;
        else if (BAout)     w_bus = w_sel[0] ? 32'd0 : w_reg_val;
    end

    // MDR input mux: external memory data first, then the internal RAM.
    always_comb begin
        w_mdr_in = '0;
        if (Read)        w_mdr_in = Mdatain;
        else if (ReadEn) w_mdr_in = w_ram_rd;
    end

    // ALU: increment has priority over the Y-operand operations.
    always_comb begin
        w_alu = '0;
        if (IncPC)    w_alu = w_bus + 32'd1;
        else if (ADD) w_alu = r_y + w_bus;
        else if (SUB) w_alu = r_y - w_bus;
        else if (AND) w_alu = r_y & w_bus;
    end

    // Branch condition evaluated from IR[20:19] against the bus value.
    always_comb begin
        w_con_next = 1'b0;
        case (r_ir[20:19])
            2'b00:   w_con_next = (w_bus == 32'd0);
            2'b01:   w_con_next = (w_bus != 32'd0);
            2'b10:   w_con_next = ~w_bus[31];
            default: w_con_next = w_bus[31];
        endcase
    end

    // Special-purpose registers, each loading on its own strobe.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            r_pc      <= '0;
            r_ir      <= '0;
            r_mar     <= '0;
            r_mdr     <= '0;
            r_y       <= '0;
            r_z       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_inport  <= '0;
            r_outport <= '0;
            r_con     <= 1'b0;
        end else begin
            if (PCin)      r_pc      <= w_bus;
            if (IRin)      r_ir      <= w_bus;
            if (MARin)     r_mar     <= w_bus;
            if (MDRin)     r_mdr     <= w_mdr_in;
            if (Yin)       r_y       <= w_bus;
            if (Zin)       r_z       <= {32'd0, w_alu};
            if (HIin)      r_hi      <= w_bus;
            if (LOin)      r_lo      <= w_bus;
            if (Strobe)    r_inport  <= InPort_data;
            if (OutPortin) r_outport <= w_bus;
            if (CONIn)     r_con     <= w_con_next;
        end
    end

    // General register file: Rin writes the bus into every selected register.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            for (int i = 0; i < 16; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (Rin && w_sel[i]) r_regs[i] <= w_bus;
            end
        end
    end

    // Internal RAM write; a write coinciding with Clear is dropped.
    always_ff @(posedge Clock) begin
        if (Write && Clear) r_ram[r_mar[8:0]] <= r_mdr;
    end

endmodule

// File: tb/tb_datapath_p2.sv
// tb_datapath_p2: directed walk through the datapath transfers followed by
// randomized strobes, all checked against a transfer-level model of the datapath.
module tb_datapath_p2;

    logic        Clock = 1'b0;
    logic        Clear;
    logic [31:0] outp;
    logic PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout;
    logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin;
    logic IncPC, Read, Write, ReadEn, Gra, Grb, Grc, Rin, Rout, BAout, Cout;
    logic CONIn, Strobe, SUB, AND, ADD;
    logic [31:0] Mdatain, InPort_data;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Clock.
    always #5 Clock = ~Clock;

    datapath_p2 dut (
        .outp(outp), .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout),
        .MDRout(MDRout), .HIout(HIout), .LOout(LOout), .InPortout(InPortout),
        .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .HIin(HIin), .LOin(LOin), .OutPortin(OutPortin),
        .IncPC(IncPC), .Read(Read), .Write(Write), .ReadEn(ReadEn),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Cout(Cout), .CONIn(CONIn), .Strobe(Strobe), .Clock(Clock), .Clear(Clear),
        .Mdatain(Mdatain), .InPort_data(InPort_data), .SUB(SUB), .AND(AND), .ADD(ADD)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_r [16];
    logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_hi, m_lo, m_inport, m_outport;
    logic [63:0] m_z;
    logic        m_con;
    logic [31:0] m_ram [512];
    bit          m_written [512];

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_r[i] = '0;
        m_pc = '0; m_ir = '0; m_mar = '0; m_mdr = '0; m_y = '0;
        m_hi = '0; m_lo = '0; m_inport = '0; m_outport = '0;
        m_z = '0; m_con = 1'b0;
    endtask

    // Lowest register index named by an enabled field, or -1 if none.
    function automatic int m_lowest();
        int lo = 16;
        if (Gra && int'(m_ir[26:23]) < lo) lo = int'(m_ir[26:23]);
        if (Grb && int'(m_ir[22:19]) < lo) lo = int'(m_ir[22:19]);
        if (Grc && int'(m_ir[18:15]) < lo) lo = int'(m_ir[18:15]);
        return (lo == 16) ? -1 : lo;
    endfunction

    function automatic logic [31:0] m_bus();
        int lo;
        lo = m_lowest();
        if (MDRout)    return m_mdr;
        if (PCout)     return m_pc;
        if (Zlowout)   return m_z[31:0];
        if (Zhiout)    return m_z[63:32];
        if (HIout)     return m_hi;
        if (LOout)     return m_lo;
        if (InPortout) return m_inport;
        if (Cout)      return 32'($signed(m_ir[18:0]));
        if (Rout || BAout) begin
            if (lo < 0) return 32'd0;
            if (BAout && lo == 0) return 32'd0;
            return m_r[lo];
        end
        return 32'd0;
    endfunction

    task automatic m_update();
        logic [31:0] b, rd, o_ir, o_mar, o_mdr, o_y, alu;
        b = m_bus();
        o_ir = m_ir; o_mar = m_mar; o_mdr = m_mdr; o_y = m_y;
        rd = m_ram[o_mar[8:0]];
        if (IncPC)    alu = b + 1;
        else if (ADD) alu = o_y + b;
        else if (SUB) alu = o_y - b;
        else if (AND) alu = o_y & b;
        else          alu = 0;
        if (Write) begin
            m_ram[o_mar[8:0]] = o_mdr;
            m_written[o_mar[8:0]] = 1'b1;
        end
        if (MARin)     m_mar = b;
        if (PCin)      m_pc = b;
        if (IRin)      m_ir = b;
        if (Yin)       m_y = b;
        if (HIin)      m_hi = b;
        if (LOin)      m_lo = b;
        if (OutPortin) m_outport = b;
        if (Strobe)    m_inport = InPort_data;
        if (MDRin)     m_mdr = Read ? Mdatain : (ReadEn ? rd : 32'd0);
        if (Zin)       m_z = {32'd0, alu};
        if (CONIn) begin
            case (o_ir[20:19])
                2'd0: m_con = (b == 0);
                2'd1: m_con = (b != 0);
                2'd2: m_con = (b[31] == 1'b0);
                default: m_con = (b[31] == 1'b1);
            endcase
        end
        if (Rin) begin
            if (Gra) m_r[o_ir[26:23]] = b;
            if (Grb) m_r[o_ir[22:19]] = b;
            if (Grc) m_r[o_ir[18:15]] = b;
        end
    endtask

    // Model follows the same edges the datapath reacts to.
    always @(posedge Clock or negedge Clear) begin
        if (!Clear) m_reset();
        else m_update();
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare every cycle, mid-phase, while inputs are stable.
    always @(negedge Clock) begin
        if (chk_en) begin
            check("outp", outp, m_bus());
            check("pc", dut.r_pc, m_pc);
            check("ir", dut.r_ir, m_ir);
            check("mar", dut.r_mar, m_mar);
            check("mdr", dut.r_mdr, m_mdr);
            check("y", dut.r_y, m_y);
            check("z", dut.r_z, m_z);
            check("hi", dut.r_hi, m_hi);
            check("lo", dut.r_lo, m_lo);
            check("inport", dut.r_inport, m_inport);
            check("outport", dut.r_outport, m_outport);
            check("con", dut.r_con, m_con);
            for (int i = 0; i < 16; i++) check($sformatf("r%0d", i), dut.r_regs[i], m_r[i]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        PCout = 0; Zhiout = 0; Zlowout = 0; MDRout = 0; HIout = 0; LOout = 0; InPortout = 0;
        MARin = 0; Zin = 0; PCin = 0; MDRin = 0; IRin = 0; Yin = 0; HIin = 0; LOin = 0;
        OutPortin = 0; IncPC = 0; Read = 0; Write = 0; ReadEn = 0; Gra = 0; Grb = 0; Grc = 0;
        Rin = 0; Rout = 0; BAout = 0; Cout = 0; CONIn = 0; Strobe = 0; SUB = 0; AND = 0; ADD = 0;
    endtask

    // Apply the currently driven strobes for one edge, then drop them.
    task automatic step();
        @(posedge Clock);
        #2;
        idle();
    endtask

    task automatic load_mdr(input logic [31:0] v);
        Read = 1; MDRin = 1; Mdatain = v;
        step();
    endtask

    task automatic rand_inputs();
        int k;
        PCout     = ($urandom_range(0, 7) == 0);
        Zhiout    = ($urandom_range(0, 7) == 0);
        Zlowout   = ($urandom_range(0, 7) == 0);
        MDRout    = ($urandom_range(0, 7) == 0);
        HIout     = ($urandom_range(0, 7) == 0);
        LOout     = ($urandom_range(0, 7) == 0);
        InPortout = ($urandom_range(0, 7) == 0);
        Cout      = ($urandom_range(0, 7) == 0);
        k = int'($urandom_range(0, 3));
        Rout  = (k == 0);
        BAout = (k == 1);
        MARin = ($urandom_range(0, 3) == 0); Zin = ($urandom_range(0, 3) == 0);
        PCin = ($urandom_range(0, 3) == 0); MDRin = ($urandom_range(0, 3) == 0);
        IRin = ($urandom_range(0, 3) == 0); Yin = ($urandom_range(0, 3) == 0);
        HIin = ($urandom_range(0, 3) == 0); LOin = ($urandom_range(0, 3) == 0);
        OutPortin = ($urandom_range(0, 3) == 0); Rin = ($urandom_range(0, 3) == 0);
        CONIn = ($urandom_range(0, 3) == 0); Strobe = ($urandom_range(0, 3) == 0);
        IncPC = ($urandom_range(0, 3) == 0);
        ADD = 1'($urandom_range(0, 1)); SUB = 1'($urandom_range(0, 1)); AND = 1'($urandom_range(0, 1));
        Gra = 1'($urandom_range(0, 1)); Grb = 1'($urandom_range(0, 1)); Grc = 1'($urandom_range(0, 1));
        Read = 1'($urandom_range(0, 1));
        ReadEn = 1'($urandom_range(0, 1)) & m_written[m_mar[8:0]];
        Write = ($urandom_range(0, 7) == 0);
        case ($urandom_range(0, 3))
            0: Mdatain = 32'd0;
            1: Mdatain = 32'h8000_0000 | $urandom;
            2: Mdatain = 32'($urandom_range(0, 600));
            default: Mdatain = $urandom;
        endcase
        InPort_data = $urandom;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        idle();
        Mdatain = 0; InPort_data = 0;
        Clear = 0;
        m_reset();
        for (int i = 0; i < 512; i++) m_written[i] = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        check("rst_outp", outp, 0);
        check("rst_pc", dut.r_pc, 0);
        check("rst_mdr", dut.r_mdr, 0);
        check("rst_z", dut.r_z, 0);
        check("rst_r5", dut.r_regs[5], 0);
        check("rst_con", dut.r_con, 0);
        @(posedge Clock);
        #2;
        Clear = 1;
        chk_en = 1;

        // RAM write then read back through MDR.
        load_mdr(85);
        MDRout = 1; MARin = 1; step();
        load_mdr(15);
        MDRout = 1; Write = 1; step();
        load_mdr(0);
        ReadEn = 1; MDRin = 1; step();
        check("ram85_read", dut.r_mdr, 15);

        // Register load through Ra.
        load_mdr(32'h0080_0000);
        MDRout = 1; IRin = 1; step();
        load_mdr(10);
        MDRout = 1; Gra = 1; Rin = 1; step();
        check("r1_load", dut.r_regs[1], 10);
        load_mdr(0);
        MDRout = 1; IRin = 1; step();
        MDRout = 1; Gra = 1; Rin = 1; step();
        check("r0_load", dut.r_regs[0], 0);

        // Load-instruction sequence.
        PCout = 1; MARin = 1; IncPC = 1; Zin = 1; step();
        check("t0_mar", dut.r_mar, 0);
        check("t0_z", dut.r_z, 1);
        Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h0080_0055; step();
        check("t1_pc", dut.r_pc, 1);
        MDRout = 1; IRin = 1; step();
        check("t2_ir", dut.r_ir, 32'h0080_0055);
        Grb = 1; BAout = 1; Yin = 1; step();
        check("t3_y", dut.r_y, 0);
        Cout = 1; ADD = 1; Zin = 1; step();
        check("t4_z", dut.r_z, 85);
        Zlowout = 1; MARin = 1; step();
        check("t5_mar", dut.r_mar, 85);
        ReadEn = 1; MDRin = 1; step();
        check("t6_mdr", dut.r_mdr, 15);
        MDRout = 1; Gra = 1; Rin = 1; step();
        check("t7_r1", dut.r_regs[1], 15);

        // BAout versus Rout with R0 selected.
        load_mdr(7);
        MDRout = 1; Grb = 1; Rin = 1; step();
        Grb = 1; BAout = 1; #1;
        check("baout_r0", outp, 0);
        BAout = 0; Rout = 1; #1;
        check("rout_r0", outp, 7);
        step();

        // CON flip-flop conditions.
        load_mdr(0);
        MDRout = 1; IRin = 1; step();
        CONIn = 1; step();
        check("con_eq0", dut.r_con, 1);
        load_mdr(32'h0018_0000);
        MDRout = 1; IRin = 1; step();
        load_mdr(32'h8000_0000);
        MDRout = 1; CONIn = 1; step();
        check("con_neg", dut.r_con, 1);
        load_mdr(32'h0008_0000);
        MDRout = 1; IRin = 1; step();
        CONIn = 1; step();
        check("con_ne0", dut.r_con, 0);

        // Negative constant sign extension and wrap-around add.
        load_mdr(32'h0007_FFFF);
        MDRout = 1; IRin = 1; step();
        Cout = 1; Yin = 1; #1;
        check("cout_sext", outp, 32'hFFFF_FFFF);
        step();
        load_mdr(1);
        MDRout = 1; ADD = 1; Zin = 1; step();
        check("add_wrap", dut.r_z, 0);

        // Reset during a RAM write must not disturb the RAM.
        load_mdr(0);
        MDRout = 1; MARin = 1; step();
        load_mdr(32'h0000_1234);
        Write = 1; step();
        Write = 1; Clear = 0;
        @(posedge Clock);
        #2;
        Clear = 1; idle();
        check("clr_mdr", dut.r_mdr, 0);
        ReadEn = 1; MDRin = 1; step();
        check("clr_ram_kept", dut.r_mdr, 32'h0000_1234);

        // Randomized strobes.
        repeat (2000) begin
            rand_inputs();
            step();
        end

        @(negedge Clock);
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
